uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller (start/data/parity/stop).
// Counts oversample ticks, takes bit decisions from sampled_bit at each bit end.
//
// Ports:
//   CLK          in   oversampling clock, rising edge
//   RST          in   asynchronous reset, active low
//   RX_IN        in   serial line, idle high
//   Prescale     in   oversampling ratio (8/16/32, anything else -> 8)
//   PAR_EN       in   parity bit present
//   PAR_TYP      in   0 even, 1 odd
//   sampled_bit  in   majority-vote bit from the sampler
//   data_samp_en out  sampler enable (high outside IDLE)
//   edge_cnt     out  oversample position within current bit
//   P_DATA       out  last good received word
//   data_valid   out  one-cycle pulse when P_DATA is updated
//   par_err      out  parity error flag of last frame
//   stp_err      out  stop error flag of last frame
//
// Optional feature macro: UART_RX_START_GLITCH_CHECK_EN
//   defined   -> a start bit that samples high at its bit end is dropped
//   undefined -> the start bit is always accepted

module uart_rx_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int PRESCALE_MAX = 32
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            RX_IN,
  input  logic [5:0]                      Prescale,
  input  logic                            PAR_EN,
  input  logic                            PAR_TYP,
  input  logic                            sampled_bit,
  output logic                            data_samp_en,
  output logic [$clog2(PRESCALE_MAX)-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0]           P_DATA,
  output logic                            data_valid,
  output logic                            par_err,
  output logic                            stp_err
);

  localparam int EW = $clog2(PRESCALE_MAX);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [EW-1:0]         last_q, last_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;

  logic [5:0]            pre_norm;
  logic [EW-1:0]         last_start;
  logic                  bit_end;
  logic                  par_exp;

  // Illegal ratios fall back to 8.
  always_comb begin
    pre_norm = 6'd8;
    if (Prescale == 6'd16 && PRESCALE_MAX >= 16) begin
      pre_norm = 6'd16;
    end else if (Prescale == 6'd32 && PRESCALE_MAX >= 32) begin
      pre_norm = 6'd32;
    end
  end

  // Store the last tick index rather than the ratio itself.
  assign last_start = EW'(pre_norm - 6'd1);
  assign bit_end    = (edge_q == last_q);
  assign par_exp    = (^shift_q) ^ ptyp_q;

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    last_d  = last_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pdata_d = pdata_q;
    dv_d    = 1'b0;
    perr_d  = perr_q;
    serr_d  = serr_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;

    if (state_q != IDLE) begin
      edge_d = bit_end ? '0 : edge_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        edge_d = '0;
        // The detection cycle is tick 0 of the start bit.
        if (!RX_IN) begin
          state_d = START;
          edge_d  = EW'(1);
          perr_d  = 1'b0;
          serr_d  = 1'b0;
          last_d  = last_start;
          pen_d   = PAR_EN;
          ptyp_d  = PAR_TYP;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d = '0;
`ifdef UART_RX_START_GLITCH_CHECK_EN
          state_d = sampled_bit ? IDLE : DATA;
`else
          state_d = DATA;
`endif
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d[bit_q] = sampled_bit;
          if (bit_q == LAST_BIT) begin
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          perr_d  = (sampled_bit != par_exp);
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          serr_d  = ~sampled_bit;
          state_d = IDLE;
          if (!perr_q && sampled_bit) begin
            pdata_d = shift_q;
            dv_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      edge_q  <= '0;
      last_q  <= EW'(7);
      bit_q   <= '0;
      shift_q <= '0;
      pdata_q <= '0;
      dv_q    <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pdata_q <= pdata_d;
      dv_q    <= dv_d;
      perr_q  <= perr_d;
      serr_q  <= serr_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
    end
  end

  assign data_samp_en = (state_q != IDLE);
  assign edge_cnt     = edge_q;
  assign P_DATA       = pdata_q;
  assign data_valid   = dv_q;
  assign par_err      = perr_q;
  assign stp_err      = serr_q;

endmodule
